// File: rtl/amm2ahb_pkg.sv
// Shared AHB-Lite / Avalon-MM encodings and the byteenable decode result type for amm2ahb.
package amm2ahb_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HsizeByte = 2'b00,
    HsizeHalf = 2'b01,
    HsizeWord = 2'b10
  } hsize_e;

  localparam logic [2:0] HburstSingle = 3'b000;

  // 01 is reserved on Avalon-MM
  typedef enum logic [1:0] {
    AmmRespOkay        = 2'b00,
    AmmRespSlverr      = 2'b10,
    AmmRespDecodeerror = 2'b11
  } amm_resp_e;

  typedef struct packed {
    logic       legal;
    logic [1:0] hsize;
    logic [1:0] offset;
  } be_dec_t;

endpackage

// File: rtl/amm2ahb_if.sv
// Avalon-MM slave + AHB-Lite master signal bundle for amm2ahb.
// amm_response exists only when AMM2AHB_RESPONSE_EN is defined.
interface amm2ahb_if;
  logic [31:0] amm_address;
  logic [31:0] amm_writedata;
  logic [3:0]  amm_byteenable;
  logic        amm_write;
  logic        amm_read;
  logic [31:0] amm_readdata;
  logic        amm_waitrequest;
`ifdef AMM2AHB_RESPONSE_EN
  logic [1:0]  amm_response;
`endif

  logic [31:0] m_haddr;
  logic [1:0]  m_hsize;
  logic [2:0]  m_hburst;
  logic [3:0]  m_hprot;
  logic [1:0]  m_htrans;
  logic [31:0] m_hwdata;
  logic        m_hlock;
  logic        m_hwrite;
  logic [31:0] m_hrdata;
  logic        m_hresp;
  logic        m_hready;

`ifdef AMM2AHB_RESPONSE_EN
  // Bridge side: Avalon slave toward the host, AHB master toward the bus
  modport slave (
    input  amm_address, amm_writedata, amm_byteenable, amm_write, amm_read,
    input  m_hrdata, m_hresp, m_hready,
    output amm_readdata, amm_waitrequest, amm_response,
    output m_haddr, m_hsize, m_hburst, m_hprot, m_htrans, m_hwdata, m_hlock, m_hwrite
  );
  modport master (
    output amm_address, amm_writedata, amm_byteenable, amm_write, amm_read,
    output m_hrdata, m_hresp, m_hready,
    input  amm_readdata, amm_waitrequest, amm_response,
    input  m_haddr, m_hsize, m_hburst, m_hprot, m_htrans, m_hwdata, m_hlock, m_hwrite
  );
`else
  modport slave (
    input  amm_address, amm_writedata, amm_byteenable, amm_write, amm_read,
    input  m_hrdata, m_hresp, m_hready,
    output amm_readdata, amm_waitrequest,
    output m_haddr, m_hsize, m_hburst, m_hprot, m_htrans, m_hwdata, m_hlock, m_hwrite
  );
  modport master (
    output amm_address, amm_writedata, amm_byteenable, amm_write, amm_read,
    output m_hrdata, m_hresp, m_hready,
    input  amm_readdata, amm_waitrequest,
    input  m_haddr, m_hsize, m_hburst, m_hprot, m_htrans, m_hwdata, m_hlock, m_hwrite
  );
`endif
endinterface

// File: rtl/amm2ahb_be_decode.sv
// Combinational Avalon byteenable -> {legal, AHB hsize, haddr[1:0]} decode.
module amm2ahb_be_decode
  import amm2ahb_pkg::*;
(
  input  logic [3:0] byteenable_i,
  output be_dec_t    dec_o
);

  always_comb begin
    dec_o.legal  = 1'b0;
    dec_o.hsize  = HsizeByte;
    dec_o.offset = 2'b00;
    case (byteenable_i)
      4'b1111: begin
        dec_o.legal = 1'b1;
        dec_o.hsize = HsizeWord;
      end
      4'b0011: begin
        dec_o.legal = 1'b1;
        dec_o.hsize = HsizeHalf;
      end
      4'b1100: begin
        dec_o.legal  = 1'b1;
        dec_o.hsize  = HsizeHalf;
        dec_o.offset = 2'b10;
      end
      4'b0001: dec_o.legal = 1'b1;
      4'b0010: begin
        dec_o.legal  = 1'b1;
        dec_o.offset = 2'b01;
      end
      4'b0100: begin
        dec_o.legal  = 1'b1;
        dec_o.offset = 2'b10;
      end
      4'b1000: begin
        dec_o.legal  = 1'b1;
        dec_o.offset = 2'b11;
      end
      default: dec_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/amm2ahb.sv
// Avalon-MM slave to AHB-Lite master bridge: one Avalon access -> one SINGLE AHB transfer.
// Define AMM2AHB_RESPONSE_EN to expose amm_response (OKAY/SLVERR/DECODEERROR).
module amm2ahb
  import amm2ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input logic      hclk,
  input logic      reset,
  amm2ahb_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  hsize_q, hsize_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] readdata_q, readdata_d;
  logic        waitrequest_q, waitrequest_d;
  logic [1:0]  response_q, response_d;

  be_dec_t dec;
  logic    req;
  logic    unused_addr_lsb;

  amm2ahb_be_decode u_be_decode (
    .byteenable_i (bus.amm_byteenable),
    .dec_o        (dec)
  );

  assign req             = bus.amm_read | bus.amm_write;
  // Low address bits come from the byteenable decode instead
  assign unused_addr_lsb = ^bus.amm_address[1:0];

  always_comb begin
    state_d       = state_q;
    htrans_d      = htrans_q;
    haddr_d       = haddr_q;
    hsize_d       = hsize_q;
    hwrite_d      = hwrite_q;
    hwdata_d      = hwdata_q;
    wdata_d       = wdata_q;
    readdata_d    = readdata_q;
    waitrequest_d = waitrequest_q;
    response_d    = response_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (dec.legal) begin
            haddr_d  = {bus.amm_address[31:2], dec.offset};
            hsize_d  = dec.hsize;
            hwrite_d = bus.amm_write;
            wdata_d  = bus.amm_writedata;
            htrans_d = HtransNonseq;
            state_d  = StAddr;
          end else begin
            readdata_d = '0;
            response_d = AmmRespDecodeerror;
            state_d    = StDone;
          end
        end
      end
      StAddr: begin
        if (bus.m_hready) begin
          htrans_d = HtransIdle;
          hwdata_d = wdata_q;
          state_d  = StData;
        end
      end
      StData: begin
        // htrans is already IDLE here, so an ERROR response needs no cancel
        if (bus.m_hready) begin
          readdata_d    = (hwrite_q || bus.m_hresp) ? '0 : bus.m_hrdata;
          response_d    = bus.m_hresp ? AmmRespSlverr : AmmRespOkay;
          waitrequest_d = 1'b0;
          state_d       = StDone;
        end
      end
      StDone: begin
        // A rejected request arrives with waitrequest still high and drops it here first
        if (waitrequest_q) begin
          waitrequest_d = 1'b0;
        end else begin
          waitrequest_d = 1'b1;
          readdata_d    = '0;
          response_d    = AmmRespOkay;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (reset) begin
      state_q       <= StIdle;
      htrans_q      <= HtransIdle;
      haddr_q       <= '0;
      hsize_q       <= '0;
      hwrite_q      <= 1'b0;
      hwdata_q      <= '0;
      wdata_q       <= '0;
      readdata_q    <= '0;
      waitrequest_q <= 1'b1;
      response_q    <= AmmRespOkay;
    end else begin
      state_q       <= state_d;
      htrans_q      <= htrans_d;
      haddr_q       <= haddr_d;
      hsize_q       <= hsize_d;
      hwrite_q      <= hwrite_d;
      hwdata_q      <= hwdata_d;
      wdata_q       <= wdata_d;
      readdata_q    <= readdata_d;
      waitrequest_q <= waitrequest_d;
      response_q    <= response_d;
    end
  end

  assign bus.m_htrans        = htrans_q;
  assign bus.m_haddr         = haddr_q;
  assign bus.m_hsize         = hsize_q;
  assign bus.m_hwrite        = hwrite_q;
  assign bus.m_hwdata        = hwdata_q;
  assign bus.m_hburst        = HburstSingle;
  assign bus.m_hlock         = 1'b0;
  assign bus.m_hprot         = HPROT_VAL;
  assign bus.amm_readdata    = readdata_q;
  assign bus.amm_waitrequest = waitrequest_q;

`ifdef AMM2AHB_RESPONSE_EN
  assign bus.amm_response = response_q;
`else
  logic unused_response;
  assign unused_response = ^response_q;
`endif

endmodule

// File: tb/tb_amm2ahb.sv
// Scoreboard bench for amm2ahb: directed Avalon accesses against a small AHB slave model.
// Response codes are checked only when AMM2AHB_RESPONSE_EN is defined.
module tb_amm2ahb;
  import amm2ahb_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
  } amm_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        write;
    logic [31:0] wdata;
  } ahb_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  amm2ahb_if bus ();

  amm2ahb #(.HPROT_VAL(4'b0011)) dut (
    .hclk  (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  amm_exp_t    amm_q[$];
  ahb_exp_t    ahb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          req_cycle = 0;
  int          sl_wait = 0;
  bit          sl_err = 1'b0;
  logic [31:0] sl_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // AHB slave: data phase follows an accepted NONSEQ, with sl_wait stall cycles
  initial begin
    bit addr_acc, dp_done, dp_active;
    int dp_cnt;
    dp_active = 1'b0;
    dp_cnt = 0;
    forever begin
      @(negedge clk);
      addr_acc = (bus.m_htrans === HtransNonseq) && (bus.m_hready === 1'b1);
      dp_done  = dp_active && (bus.m_hready === 1'b1);
      @(posedge clk);
      #1;
      if (dp_done) begin
        dp_active    = 1'b0;
        bus.m_hready = 1'b1;
        bus.m_hresp  = 1'b0;
        bus.m_hrdata = '0;
      end
      if (addr_acc) begin
        dp_active = 1'b1;
        dp_cnt    = 0;
      end
      if (dp_active) begin
        if (dp_cnt < sl_wait) begin
          bus.m_hready = 1'b0;
          bus.m_hresp  = 1'b0;
        end else if (sl_err && dp_cnt == sl_wait) begin
          bus.m_hready = 1'b0;
          bus.m_hresp  = 1'b1;
        end else begin
          bus.m_hready = 1'b1;
          bus.m_hresp  = sl_err;
          bus.m_hrdata = sl_rdata;
        end
        dp_cnt++;
      end
    end
  end

  // Monitor: AHB address/data phases and Avalon completions against the queues
  initial begin
    bit          m_dp, m_dp_write, prev_stall;
    logic [31:0] m_dp_wdata, prev_addr;
    logic [1:0]  prev_size;
    logic        prev_write;
    ahb_exp_t    a;
    amm_exp_t    m;
    m_dp = 1'b0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("nonseq_held", bus.m_htrans, HtransNonseq);
          check("haddr_stable", bus.m_haddr, prev_addr);
          check("hsize_stable", bus.m_hsize, prev_size);
          check("hwrite_stable", bus.m_hwrite, prev_write);
        end
        prev_stall = (bus.m_htrans == HtransNonseq) && !bus.m_hready;
        prev_addr  = bus.m_haddr;
        prev_size  = bus.m_hsize;
        prev_write = bus.m_hwrite;
        if (m_dp && bus.m_hready) begin
          if (m_dp_write) check("hwdata", bus.m_hwdata, m_dp_wdata);
          m_dp = 1'b0;
        end
        if (bus.m_htrans == HtransNonseq && bus.m_hready) begin
          if (ahb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_nonseq: got haddr 0x%08h, expected no transfer", bus.m_haddr);
          end else begin
            a = ahb_q.pop_front();
            check("haddr", bus.m_haddr, a.addr);
            check("hsize", bus.m_hsize, a.size);
            check("hwrite", bus.m_hwrite, a.write);
            check("hburst", bus.m_hburst, HburstSingle);
            check("hprot", bus.m_hprot, 4'b0011);
            m_dp       = 1'b1;
            m_dp_write = a.write;
            m_dp_wdata = a.wdata;
          end
        end
        if (!bus.amm_waitrequest) begin
          if (amm_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got waitrequest 0, expected 1");
          end else begin
            m = amm_q.pop_front();
            check("readdata", bus.amm_readdata, m.rdata);
            check("latency", cyc - req_cycle, m.lat);
`ifdef AMM2AHB_RESPONSE_EN
            check("response", bus.amm_response, m.resp);
`endif
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 with the request dropped
  task automatic amm_xfer(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input bit issue_ahb,
                          input logic [31:0] exp_haddr, input logic [1:0] exp_size,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                          input int exp_lat, input int addr_stall);
    ahb_exp_t a;
    amm_exp_t m;
    bit done;
    if (issue_ahb) begin
      a.addr  = exp_haddr;
      a.size  = exp_size;
      a.write = wr;
      a.wdata = wdata;
      ahb_q.push_back(a);
    end
    m.rdata = exp_rdata;
    m.resp  = exp_resp;
    m.lat   = exp_lat;
    amm_q.push_back(m);
    if (addr_stall > 0) bus.m_hready = 1'b0;
    bus.amm_read       = rd;
    bus.amm_write      = wr;
    bus.amm_address    = addr;
    bus.amm_writedata  = wdata;
    bus.amm_byteenable = be;
    req_cycle = cyc;
    done = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!bus.amm_waitrequest) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (k == addr_stall) bus.m_hready = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no completion for addr 0x%08h, expected one within 40 cycles",
               addr);
    end
    @(posedge clk);
    #1;
    bus.amm_read       = 1'b0;
    bus.amm_write      = 1'b0;
    bus.amm_byteenable = '0;
  endtask

  initial begin
    ahb_exp_t a;
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish before 200000");
    $fatal(1);
  end

  initial begin
    ahb_exp_t a;
    bus.amm_read       = 1'b0;
    bus.amm_write      = 1'b0;
    bus.amm_address    = '0;
    bus.amm_writedata  = '0;
    bus.amm_byteenable = '0;
    bus.m_hready       = 1'b1;
    bus.m_hresp        = 1'b0;
    bus.m_hrdata       = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_htrans", bus.m_htrans, HtransIdle);
    check("rst_haddr", bus.m_haddr, 32'h0);
    check("rst_hsize", bus.m_hsize, 2'b00);
    check("rst_hwrite", bus.m_hwrite, 1'b0);
    check("rst_hwdata", bus.m_hwdata, 32'h0);
    check("rst_readdata", bus.amm_readdata, 32'h0);
    check("rst_waitrequest", bus.amm_waitrequest, 1'b1);
    check("rst_hburst", bus.m_hburst, 3'b000);
    check("rst_hlock", bus.m_hlock, 1'b0);
    check("rst_hprot", bus.m_hprot, 4'b0011);
`ifdef AMM2AHB_RESPONSE_EN
    check("rst_response", bus.amm_response, 2'b00);
`endif
    reset = 1'b0;

    // Word read, zero-wait
    sl_rdata = 32'hDEAD_BEEF;
    amm_xfer(1, 0, 32'h1000_0004, 0, 4'b1111, 1, 32'h1000_0004, 2'd2, 32'hDEAD_BEEF, 2'b00, 3, 0);
    // Byte write lane 2; readdata must stay 0 despite hrdata
    amm_xfer(0, 1, 32'h20, 32'h00AB_0000, 4'b0100, 1, 32'h22, 2'd0, 32'h0, 2'b00, 3, 0);
    // Three data-phase wait states
    sl_wait = 3;
    sl_rdata = 32'hCAFE_1234;
    amm_xfer(1, 0, 32'h100, 0, 4'b0011, 1, 32'h100, 2'd1, 32'hCAFE_1234, 2'b00, 6, 0);
    sl_wait = 0;
    // HREADY low through the address phase
    amm_xfer(0, 1, 32'h204, 32'h5A5A_0000, 4'b1100, 1, 32'h206, 2'd1, 32'h0, 2'b00, 5, 3);
    // Slave ERROR on read and on write
    sl_err = 1'b1;
    sl_rdata = 32'hBAD0_BAD0;
    amm_xfer(1, 0, 32'h300, 0, 4'b1111, 1, 32'h300, 2'd2, 32'h0, 2'b10, 4, 0);
    amm_xfer(0, 1, 32'h308, 32'h0000_00EE, 4'b0001, 1, 32'h308, 2'd0, 32'h0, 2'b10, 4, 0);
    sl_err = 1'b0;
    // Illegal byteenables: no AHB transfer
    amm_xfer(1, 0, 32'h400, 0, 4'b0110, 0, 32'h0, 2'd0, 32'h0, 2'b11, 2, 0);
    amm_xfer(0, 1, 32'h404, 32'h1, 4'b0000, 0, 32'h0, 2'd0, 32'h0, 2'b11, 2, 0);
    // Read and write together is a write
    amm_xfer(1, 1, 32'h44, 32'h0000_7777, 4'b0011, 1, 32'h44, 2'd1, 32'h0, 2'b00, 3, 0);
    // Top byte lane read
    sl_rdata = 32'hA100_0000;
    amm_xfer(1, 0, 32'h50, 0, 4'b1000, 1, 32'h53, 2'd0, 32'hA100_0000, 2'b00, 3, 0);

    // Reset during the data phase drops the command
    sl_wait = 4;
    sl_rdata = 32'h1111_2222;
    a.addr  = 32'h600;
    a.size  = 2'd2;
    a.write = 1'b0;
    a.wdata = '0;
    ahb_q.push_back(a);
    bus.amm_read       = 1'b1;
    bus.amm_address    = 32'h600;
    bus.amm_byteenable = 4'b1111;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    bus.amm_read = 1'b0;
    bus.amm_byteenable = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("postrst_htrans", bus.m_htrans, HtransIdle);
    check("postrst_waitrequest", bus.amm_waitrequest, 1'b1);
    check("postrst_readdata", bus.amm_readdata, 32'h0);
    check("postrst_haddr", bus.m_haddr, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    sl_wait = 0;
    amm_xfer(1, 0, 32'h604, 0, 4'b1111, 1, 32'h604, 2'd2, 32'h1111_2222, 2'b00, 3, 0);

    // Back-to-back reads from a fixed-data slave
    sl_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      amm_xfer(1, 0, 32'h700 + 32'(4 * i), 0, 4'b1111, 1, 32'h700 + 32'(4 * i), 2'd2,
               32'h1234_5678, 2'b00, 3, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("amm_q_drained", amm_q.size(), 0);
    check("ahb_q_drained", ahb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
